axil_wr_arbiter: RTL

Round-robin arbiter that shares a single AXI-lite write master port among S_COUNT AXI-lite write requesters. It captures one AW+W pair per grant and drives it onto the master port through registered outputs. It routes each B response back to the originating requester through an in-order ID FIFO. It sits in front of a shared register or peripheral slave wherever a full write crossbar is more than the design needs.

---
 rtl/axil_pkg.sv | 21 ++
 rtl/axil_wr_arbiter_if.sv | 31 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/axil_wr_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI-lite response codes and sizing helper for the write arbiter slice.
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axil_resp_t;

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } arb_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_wr_arbiter_if.sv
// AXI-lite write channel bundle; N lanes packed side by side for multi-requester use.
interface axil_wr_arbiter_if #(
  parameter int unsigned N          = 1,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);

  logic [N*ADDR_WIDTH-1:0] awaddr;
  logic [N*3-1:0]          awprot;
  logic [N-1:0]            awvalid;
  logic [N-1:0]            awready;
  logic [N*DATA_WIDTH-1:0] wdata;
  logic [N*STRB_WIDTH-1:0] wstrb;
  logic [N-1:0]            wvalid;
  logic [N-1:0]            wready;
  logic [N*2-1:0]          bresp;
  logic [N-1:0]            bvalid;
  logic [N-1:0]            bready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting index after last_grant, wrapping.
module rr_arbiter
  import axil_pkg::*;
#(
  parameter  int unsigned S_COUNT = 4,
  localparam int unsigned IDW     = idw(S_COUNT)
) (
  input  logic [S_COUNT-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [S_COUNT-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               grant_valid
);

  int unsigned idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int unsigned k = 1; k <= S_COUNT; k++) begin
      idx = 32'(last_grant) + k;
      if (idx >= S_COUNT) idx = idx - S_COUNT;
      if (!grant_valid && req[IDW'(idx)]) begin
        grant_valid          = 1'b1;
        grant_idx            = IDW'(idx);
        grant[IDW'(idx)]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_wr_arbiter.sv
// Round-robin AXI-lite write arbiter: one AW+W pair per grant onto a shared master,
// B responses steered back through an in-order ID FIFO.
module axil_wr_arbiter
  import axil_pkg::*;
#(
  parameter int unsigned S_COUNT    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned M_ISSUE    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axil_wr_arbiter_if.slave       s_axil,
  axil_wr_arbiter_if.master      m_axil
);

  localparam int unsigned IDW = idw(S_COUNT);
  localparam int unsigned PW  = idw(M_ISSUE);
  localparam int unsigned CW  = $clog2(M_ISSUE + 1);

  arb_state_t           state;
  logic [IDW-1:0]       last_grant;
  logic [S_COUNT-1:0]   eligible;
  logic [S_COUNT-1:0]   grant_oh;
  logic [IDW-1:0]       grant_idx;
  logic                 grant_valid;
  logic                 grant_en;

  logic [IDW-1:0]       fifo_mem [M_ISSUE];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [IDW-1:0]       head;
  logic                 fifo_nempty;
  logic                 push;
  logic                 pop;
  logic                 aw_fin;
  logic                 w_fin;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [2:0]            sel_prot;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [STRB_WIDTH-1:0] sel_strb;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(M_ISSUE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign eligible = s_axil.awvalid & s_axil.wvalid;

  rr_arbiter #(
    .S_COUNT (S_COUNT)
  ) u_rr (
    .req         (eligible),
    .last_grant  (last_grant),
    .grant       (grant_oh),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Grant depends only on registered state and requester valids, never on master readys.
  assign grant_en = rst_n && (state == ST_IDLE) && grant_valid && (count < CW'(M_ISSUE));

  assign s_axil.awready = grant_en ? grant_oh : '0;
  assign s_axil.wready  = grant_en ? grant_oh : '0;

  assign sel_addr = s_axil.awaddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_prot = s_axil.awprot[grant_idx*3 +: 3];
  assign sel_data = s_axil.wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_strb = s_axil.wstrb[grant_idx*STRB_WIDTH +: STRB_WIDTH];

  // A channel is finished once its valid has dropped or it handshakes this cycle.
  assign aw_fin = !m_axil.awvalid[0] || m_axil.awready[0];
  assign w_fin  = !m_axil.wvalid[0]  || m_axil.wready[0];
  assign push   = (state == ST_XFER) && aw_fin && w_fin;

  assign fifo_nempty = (count != '0);
  assign head        = fifo_mem[rd_ptr];
  assign pop         = fifo_nempty && m_axil.bvalid[0] && s_axil.bready[head];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      last_grant     <= IDW'(S_COUNT - 1);
      m_axil.awvalid <= '0;
      m_axil.wvalid  <= '0;
      m_axil.awaddr  <= '0;
      m_axil.awprot  <= '0;
      m_axil.wdata   <= '0;
      m_axil.wstrb   <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_en) begin
            m_axil.awaddr  <= sel_addr;
            m_axil.awprot  <= sel_prot;
            m_axil.wdata   <= sel_data;
            m_axil.wstrb   <= sel_strb;
            m_axil.awvalid <= 1'b1;
            m_axil.wvalid  <= 1'b1;
            last_grant     <= grant_idx;
            state          <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (m_axil.awready[0]) m_axil.awvalid <= 1'b0;
          if (m_axil.wready[0])  m_axil.wvalid  <= 1'b0;
          if (push)              state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // last_grant still names the in-flight requester while in XFER.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= last_grant;
  end

  always_comb begin
    s_axil.bvalid = '0;
    s_axil.bresp  = {S_COUNT{RESP_OKAY}};
    m_axil.bready = '0;
    if (fifo_nempty) begin
      s_axil.bvalid[head]       = m_axil.bvalid[0];
      s_axil.bresp[head*2 +: 2] = m_axil.bresp;
      m_axil.bready[0]          = s_axil.bready[head];
    end
  end

endmodule
